// File: rtl/lotr_pkg.sv
// Shared display geometry and frame-buffer layout for the 640x480 1 bpp scan-out path.
package lotr_pkg;

   localparam int VGA_H_ACTIVE      = 640;
   localparam int VGA_V_ACTIVE      = 480;
   localparam int FB_WORDS_PER_LINE = 20;
   localparam int FB_FRAME_WORDS    = 9600;
   localparam int FB_ADDR_W         = 15;

   typedef struct packed {
      logic [3:0] r;
      logic [3:0] g;
      logic [3:0] b;
   } t_rgb444;

endpackage

// File: rtl/vga_fb_addr_gen.sv
// Frame-buffer read request generator: one word read at the start of every
// 32-pixel group inside the active area, address = base + Y*20 + X/32.
module vga_fb_addr_gen
   import lotr_pkg::*;
(
   input  logic [9:0]           counter_x_i,
   input  logic [9:0]           counter_y_i,
   input  logic                 base_sel_i,
   input  logic                 rd_block_i,
   output logic                 rd_en_o,
   output logic [FB_ADDR_W-1:0] rd_addr_o
);

   logic [FB_ADDR_W-1:0] line_off;
   logic [FB_ADDR_W-1:0] base;
   logic [FB_ADDR_W-1:0] y_ext;

   always_comb begin
      y_ext    = {5'b0, counter_y_i};
      // Y*20 built from shifts; 15 bits hold every Y the counters can present
      line_off = (y_ext << 4) + (y_ext << 2);
      base     = base_sel_i ? FB_ADDR_W'(FB_FRAME_WORDS) : '0;
      rd_en_o  = !rd_block_i
                 && (counter_x_i[4:0] == 5'd0)
                 && (counter_x_i < 10'(VGA_H_ACTIVE))
                 && (counter_y_i < 10'(VGA_V_ACTIVE));
      rd_addr_o = '0;
      if (rd_en_o) begin
         rd_addr_o = base + line_off + {10'b0, counter_x_i[9:5]};
      end
   end

endmodule

// File: rtl/vga_pixel_gen.sv
// 1 bpp frame-buffer scan-out: word fetch at t0, capture at t1, pixel select at t2,
// registered RGB and re-aligned syncs at t3. Buffer and colours switch only at frame start.
module vga_pixel_gen
   import lotr_pkg::*;
(
   input  logic                 CLK_25,
   input  logic                 Reset,
   input  logic [9:0]           CounterX,
   input  logic [9:0]           CounterY,
   input  logic                 inDisplayArea,
   input  logic                 vga_h_sync_in,
   input  logic                 vga_v_sync_in,
   input  logic                 buf_sel,
   input  logic [11:0]          fg_color,
   input  logic [11:0]          bg_color,
   output logic                 fb_rd_en,
   output logic [FB_ADDR_W-1:0] fb_rd_addr,
   input  logic [31:0]          fb_rd_data,
   output logic [3:0]           vga_r,
   output logic [3:0]           vga_g,
   output logic [3:0]           vga_b,
   output logic                 vga_h_sync,
   output logic                 vga_v_sync,
   output logic                 active_buf,
   output logic                 frame_start
);

   logic        frame_edge;
   logic        base_sel;

   logic        rd_en_q, rd_en_d;
   logic [31:0] word_q, word_d;
   logic        word_vld_q, word_vld_d;
   logic [4:0]  x_d1_q, x_d1_d;
   logic [4:0]  x_d2_q, x_d2_d;
   logic        de_q, de_d;
   logic        hs_d1_q, hs_d1_d, hs_d2_q, hs_d2_d;
   logic        vs_d1_q, vs_d1_d, vs_d2_q, vs_d2_d;
   t_rgb444     rgb_q, rgb_d;
   t_rgb444     fg_q, fg_d;
   t_rgb444     bg_q, bg_d;
   logic        active_buf_q, active_buf_d;
   logic        frame_start_q, frame_start_d;

   assign frame_edge = (CounterX == 10'd0) && (CounterY == 10'd0);
   // The first read of a frame happens on the boundary cycle itself, before
   // active_buf has been updated, so it takes the requested buffer directly.
   assign base_sel   = frame_edge ? buf_sel : active_buf_q;

   vga_fb_addr_gen u_addr_gen (
      .counter_x_i (CounterX),
      .counter_y_i (CounterY),
      .base_sel_i  (base_sel),
      .rd_block_i  (Reset),
      .rd_en_o     (fb_rd_en),
      .rd_addr_o   (fb_rd_addr)
   );

   always_comb begin
      rd_en_d       = fb_rd_en;
      word_d        = word_q;
      word_vld_d    = word_vld_q;
      if (rd_en_q) begin
         word_d     = fb_rd_data;
         word_vld_d = 1'b1;
      end
      x_d1_d        = CounterX[4:0];
      x_d2_d        = x_d1_q;
      de_d          = inDisplayArea;
      hs_d1_d       = vga_h_sync_in;
      hs_d2_d       = hs_d1_q;
      vs_d1_d       = vga_v_sync_in;
      vs_d2_d       = vs_d1_q;
      // word_vld keeps a post-reset line blank until a real word has arrived
      rgb_d         = '0;
      if (de_q && word_vld_q) begin
         rgb_d = word_q[x_d2_q] ? fg_q : bg_q;
      end
      frame_start_d = frame_edge;
      active_buf_d  = active_buf_q;
      fg_d          = fg_q;
      bg_d          = bg_q;
      if (frame_edge) begin
         active_buf_d = buf_sel;
         fg_d         = t_rgb444'(fg_color);
         bg_d         = t_rgb444'(bg_color);
      end
   end

   always_ff @(posedge CLK_25) begin
      if (Reset) begin
         rd_en_q       <= 1'b0;
         word_q        <= '0;
         word_vld_q    <= 1'b0;
         x_d1_q        <= '0;
         x_d2_q        <= '0;
         de_q          <= 1'b0;
         hs_d1_q       <= 1'b1;
         hs_d2_q       <= 1'b1;
         vs_d1_q       <= 1'b1;
         vs_d2_q       <= 1'b1;
         rgb_q         <= '0;
         fg_q          <= '0;
         bg_q          <= '0;
         active_buf_q  <= 1'b0;
         frame_start_q <= 1'b0;
      end else begin
         rd_en_q       <= rd_en_d;
         word_q        <= word_d;
         word_vld_q    <= word_vld_d;
         x_d1_q        <= x_d1_d;
         x_d2_q        <= x_d2_d;
         de_q          <= de_d;
         hs_d1_q       <= hs_d1_d;
         hs_d2_q       <= hs_d2_d;
         vs_d1_q       <= vs_d1_d;
         vs_d2_q       <= vs_d2_d;
         rgb_q         <= rgb_d;
         fg_q          <= fg_d;
         bg_q          <= bg_d;
         active_buf_q  <= active_buf_d;
         frame_start_q <= frame_start_d;
      end
   end

   assign vga_r       = rgb_q.r;
   assign vga_g       = rgb_q.g;
   assign vga_b       = rgb_q.b;
   assign vga_h_sync  = hs_d2_q;
   assign vga_v_sync  = vs_d2_q;
   assign active_buf  = active_buf_q;
   assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_pixel_gen.sv
// Bench for vga_pixel_gen: a behavioural sync generator and frame-buffer memory drive
// the DUT, and a pixel-level model predicts every registered and combinational output.
module tb_vga_pixel_gen;

   logic        CLK_25 = 1'b0;
   logic        Reset = 1'b1;
   logic [9:0]  CounterX = '0;
   logic [9:0]  CounterY = '0;
   logic        inDisplayArea = 1'b0;
   logic        vga_h_sync_in = 1'b1;
   logic        vga_v_sync_in = 1'b1;
   logic        buf_sel = 1'b0;
   logic [11:0] fg_color = '0;
   logic [11:0] bg_color = '0;
   logic        fb_rd_en;
   logic [14:0] fb_rd_addr;
   logic [31:0] fb_rd_data = '0;
   logic [3:0]  vga_r, vga_g, vga_b;
   logic        vga_h_sync, vga_v_sync, active_buf, frame_start;

   vga_pixel_gen dut (
      .CLK_25        (CLK_25),
      .Reset         (Reset),
      .CounterX      (CounterX),
      .CounterY      (CounterY),
      .inDisplayArea (inDisplayArea),
      .vga_h_sync_in (vga_h_sync_in),
      .vga_v_sync_in (vga_v_sync_in),
      .buf_sel       (buf_sel),
      .fg_color      (fg_color),
      .bg_color      (bg_color),
      .fb_rd_en      (fb_rd_en),
      .fb_rd_addr    (fb_rd_addr),
      .fb_rd_data    (fb_rd_data),
      .vga_r         (vga_r),
      .vga_g         (vga_g),
      .vga_b         (vga_b),
      .vga_h_sync    (vga_h_sync),
      .vga_v_sync    (vga_v_sync),
      .active_buf    (active_buf),
      .frame_start   (frame_start)
   );

   always #20 CLK_25 = ~CLK_25;

   logic [31:0] mem [0:19199];

   // synchronous frame-buffer: data valid the cycle after the strobe, garbage otherwise
   always @(posedge CLK_25) begin
      if (fb_rd_en && fb_rd_addr < 15'd19200) fb_rd_data <= mem[fb_rd_addr];
      else fb_rd_data <= $urandom;
   end

   int checks = 0;
   int failures = 0;

   // history of the last three counter values driven (index 0 = most recent)
   int          hx [3];
   int          hy [3];
   bit          hr [3];
   bit          hrd [3];
   int          ha [3];
   bit          m_buf;
   logic [11:0] m_fg, m_bg;
   bit          held_v;
   int          held_a;

   logic [15:0] obs_reg, exp_reg, obs_rd, exp_rd;

   logic [11:0] line_rgb  [0:799];
   bit          line_hs   [0:799];
   bit          line_vs   [0:799];
   bit          line_fs   [0:799];
   bit          line_ab   [0:799];
   bit          line_rd   [0:799];
   int          line_addr [0:799];

   int          tog_x = -1;
   bit          pend_buf;
   logic [11:0] pend_fg;

   function automatic bit f_de(input int x, input int y);
      return (x < 640) && (y < 480);
   endfunction

   function automatic bit f_hs(input int x);
      return !((x >= 656) && (x < 752));
   endfunction

   function automatic bit f_vs(input int y);
      return !((y >= 490) && (y < 492));
   endfunction

   // One pixel clock: sample outputs after the edge, predict them, then present new counters.
   task automatic step(input int nx, input int ny, input bit rst);
      logic [11:0] e_rgb;
      logic [31:0] w;
      bit          e_hs, e_vs, e_fs, rd;
      int          addr, base;
      @(posedge CLK_25);
      #1;
      obs_reg = {vga_r, vga_g, vga_b, vga_h_sync, vga_v_sync, frame_start, active_buf};
      e_rgb = '0;
      if (!hr[0] && !hr[1] && f_de(hx[2], hy[2]) && held_v) begin
         w = mem[held_a];
         e_rgb = w[hx[2] % 32] ? m_fg : m_bg;
      end
      e_hs = (hr[0] || hr[1]) ? 1'b1 : f_hs(hx[2]);
      e_vs = (hr[0] || hr[1]) ? 1'b1 : f_vs(hy[2]);
      e_fs = !hr[0] && (hx[0] == 0) && (hy[0] == 0);
      if (hr[0]) begin
         m_buf = 0; m_fg = '0; m_bg = '0; held_v = 0;
      end else begin
         if (hx[0] == 0 && hy[0] == 0) begin
            m_buf = buf_sel; m_fg = fg_color; m_bg = bg_color;
         end
         if (hrd[1]) begin
            held_v = 1; held_a = ha[1];
         end
      end
      exp_reg = {e_rgb, e_hs, e_vs, e_fs, m_buf};

      inDisplayArea = f_de(hx[0], hy[0]);
      vga_h_sync_in = f_hs(hx[0]);
      vga_v_sync_in = f_vs(hy[0]);
      rd   = !rst && (nx % 32 == 0) && f_de(nx, ny);
      base = ((nx == 0 && ny == 0) ? int'(buf_sel) : int'(m_buf)) * 9600;
      addr = rd ? base + ny * 20 + nx / 32 : 0;
      for (int i = 2; i > 0; i--) begin
         hx[i] = hx[i-1]; hy[i] = hy[i-1]; hr[i] = hr[i-1]; hrd[i] = hrd[i-1]; ha[i] = ha[i-1];
      end
      hx[0] = nx; hy[0] = ny; hr[0] = rst; hrd[0] = rd; ha[0] = addr;
      Reset    = rst;
      CounterX = 10'(nx);
      CounterY = 10'(ny);
      #1;
      obs_rd = {fb_rd_en, fb_rd_addr};
      exp_rd = {rd, 15'(addr)};
   endtask

   task automatic test_scan_line(input int y, input int rst_x, input int rst_len);
      for (int x = 0; x < 800; x++) begin
         step(x, y, (x >= rst_x) && (x < rst_x + rst_len));
         line_rgb[x]  = obs_reg[15:4];
         line_hs[x]   = obs_reg[3];
         line_vs[x]   = obs_reg[2];
         line_fs[x]   = obs_reg[1];
         line_ab[x]   = obs_reg[0];
         line_rd[x]   = obs_rd[15];
         line_addr[x] = int'(obs_rd[14:0]);
         checks++;
         if (obs_reg !== exp_reg) begin
            failures++;
            $display("FAIL scan_regs y=%0d x=%0d got=%h want=%h", y, x, obs_reg, exp_reg);
         end
         checks++;
         if (obs_rd !== exp_rd) begin
            failures++;
            $display("FAIL scan_rd y=%0d x=%0d got=%h want=%h", y, x, obs_rd, exp_rd);
         end
         if (x == tog_x) begin
            buf_sel  = pend_buf;
            fg_color = pend_fg;
         end
      end
   endtask

   task automatic test_reset();
      buf_sel  = 1'b1;
      fg_color = 12'($urandom);
      bg_color = 12'($urandom);
      for (int x = 0; x < 5; x++) begin
         step(x, 0, 1'b1);
         checks++;
         if (obs_reg !== 16'h000C || obs_reg !== exp_reg) begin
            failures++;
            $display("FAIL reset_regs x=%0d got=%h want=%h", x, obs_reg, 16'h000C);
         end
         checks++;
         if (obs_rd !== 16'h0000) begin
            failures++;
            $display("FAIL reset_rd x=%0d got=%h want=0000", x, obs_rd);
         end
      end
   endtask

   task automatic test_first_word();
      int n;
      for (int i = 0; i < 19200; i++) mem[i] = $urandom;
      mem[0]   = 32'h0000_0001;
      buf_sel  = 1'b0;
      fg_color = 12'($urandom);
      bg_color = fg_color ^ 12'h5A5;
      test_scan_line(524, -1, 0);
      test_scan_line(0, -1, 0);
      n = 0;
      for (int x = 0; x < 32; x++) n += int'(line_rd[x]);
      checks++;
      if (n != 1 || !line_rd[0] || line_addr[0] != 0) begin
         failures++;
         $display("FAIL first_word_reads got=%0d rd0=%0d addr0=%0d want=1 1 0", n, line_rd[0], line_addr[0]);
      end
      checks++;
      if (line_rgb[3] !== fg_color) begin
         failures++;
         $display("FAIL first_word_fg got=%h want=%h", line_rgb[3], fg_color);
      end
      n = 0;
      for (int x = 4; x < 35; x++) if (line_rgb[x] !== bg_color) n++;
      checks++;
      if (n != 0) begin
         failures++;
         $display("FAIL first_word_bg got=%0d non-bg pixels want=0", n);
      end
   endtask

   task automatic test_buffer_switch();
      int n;
      logic [11:0] old_fg;
      old_fg   = fg_color;
      pend_buf = 1'b1;
      pend_fg  = ~fg_color;
      tog_x    = 100;
      test_scan_line(1, -1, 0);
      tog_x    = -1;
      n = 0;
      for (int x = 0; x < 800; x++) if (line_ab[x] || line_rgb[x] === pend_fg) n++;
      checks++;
      if (n != 0) begin
         failures++;
         $display("FAIL switch_midframe got=%0d early-switched cycles want=0", n);
      end
      test_scan_line(479, -1, 0);
      checks++;
      if (line_addr[608] != 9599) begin
         failures++;
         $display("FAIL switch_addr_buf0 got=%0d want=9599", line_addr[608]);
      end
      test_scan_line(480, -1, 0);
      test_scan_line(524, -1, 0);
      test_scan_line(0, -1, 0);
      checks++;
      if (!line_fs[1] || line_fs[2] || line_ab[0] || !line_ab[1] || line_addr[0] != 9600) begin
         failures++;
         $display("FAIL switch_frame_start got fs=%0d%0d ab=%0d%0d addr=%0d want fs=10 ab=01 addr=9600",
                  line_fs[1], line_fs[2], line_ab[0], line_ab[1], line_addr[0]);
      end
      test_scan_line(479, -1, 0);
      checks++;
      if (line_addr[608] != 19199) begin
         failures++;
         $display("FAIL switch_addr_buf1 got=%0d want=19199", line_addr[608]);
      end
      checks++;
      if (fg_color === old_fg) begin
         failures++;
         $display("FAIL switch_fg_input got=%h want!=%h", fg_color, old_fg);
      end
   endtask

   task automatic test_frame_scan();
      int lines [12] = '{0, 1, 2, 200, 478, 479, 480, 489, 490, 491, 492, 524};
      int reads, vs_low, hs_low, outside;
      for (int i = 0; i < 19200; i++) mem[i] = $urandom;
      buf_sel = 1'b0;
      reads = 0; vs_low = 0; outside = 0;
      for (int l = 0; l < 12; l++) begin
         test_scan_line(lines[l], -1, 0);
         hs_low = 0;
         for (int x = 0; x < 800; x++) begin
            reads  += int'(line_rd[x]);
            vs_low += int'(!line_vs[x]);
            hs_low += int'(!line_hs[x]);
            if (line_rgb[x] !== 12'h000 && (x < 3 || x >= 643 || lines[l] >= 480)) outside++;
         end
         checks++;
         if (hs_low != 96) begin
            failures++;
            $display("FAIL frame_hsync_width y=%0d got=%0d want=96", lines[l], hs_low);
         end
      end
      checks++;
      if (reads != 120) begin
         failures++;
         $display("FAIL frame_reads got=%0d want=120", reads);
      end
      checks++;
      if (vs_low != 1600) begin
         failures++;
         $display("FAIL frame_vsync_width got=%0d want=1600", vs_low);
      end
      checks++;
      if (outside != 0) begin
         failures++;
         $display("FAIL frame_blanking got=%0d lit pixels outside want=0", outside);
      end
   endtask

   task automatic test_mid_frame_reset();
      int first_rd, bad;
      fg_color = 12'($urandom);
      bg_color = fg_color ^ 12'h3C3;
      test_scan_line(0, -1, 0);
      test_scan_line(100, 300, 3);
      bad = 0;
      for (int x = 301; x <= 303; x++) if (line_rgb[x] !== 12'h000 || !line_hs[x] || !line_vs[x]) bad++;
      checks++;
      if (bad != 0) begin
         failures++;
         $display("FAIL midreset_outputs got=%0d bad cycles want=0", bad);
      end
      first_rd = -1;
      for (int x = 799; x >= 300; x--) if (line_rd[x]) first_rd = x;
      checks++;
      if (first_rd != 320) begin
         failures++;
         $display("FAIL midreset_first_read got=%0d want=320", first_rd);
      end
      test_scan_line(101, -1, 0);
      test_scan_line(524, -1, 0);
   endtask

   task automatic test_checkerboard();
      int lines [6] = '{0, 1, 2, 479, 480, 524};
      for (int i = 0; i < 19200; i++) mem[i] = 32'hAAAA_AAAA;
      fg_color = 12'($urandom);
      bg_color = ~fg_color;
      buf_sel  = 1'($urandom);
      for (int l = 0; l < 6; l++) begin
         test_scan_line(lines[l], -1, 0);
         if (lines[l] < 480) begin
            checks++;
            if (line_rgb[3] !== bg_color || line_rgb[4] !== fg_color ||
                line_rgb[5] !== bg_color || line_rgb[34] !== fg_color) begin
               failures++;
               $display("FAIL checker y=%0d got=%h %h %h %h want=%h %h %h %h", lines[l],
                        line_rgb[3], line_rgb[4], line_rgb[5], line_rgb[34],
                        bg_color, fg_color, bg_color, fg_color);
            end
         end
      end
   endtask

   initial begin
      for (int i = 0; i < 3; i++) begin
         hx[i] = 0; hy[i] = 0; hr[i] = 1; hrd[i] = 0; ha[i] = 0;
      end
      m_buf = 0; m_fg = '0; m_bg = '0; held_v = 0; held_a = 0;
      test_reset();
      test_first_word();
      test_buffer_switch();
      test_frame_scan();
      test_mid_frame_reset();
      test_checkerboard();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
